// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
//   Shared types and constants for the run controller.
//   - run_state_t : sequencer states (IDLE, RESET, RUN, DONE)
//   - RST_CNT_W   : width of the reset-hold counter (covers RST_CYC up to 15)
//   - is_busy()   : true for the states in which the core is owned by a run
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    localparam int RST_CNT_W = 4;

    function automatic logic is_busy(input run_state_t s);
        return (s == RESET) || (s == RUN);
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter with synchronous clear and sticky saturation at all-ones.
//   Ports:
//     clk   - clock, all logic on posedge
//     rst_n - asynchronous active-low reset (count -> 0)
//     clr   - synchronous clear, has priority over inc
//     inc   - increment by one unless already all-ones
//     cnt   - current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
//   Start/done handshake sequencer for the single-cycle core. Holds the core
//   in reset, releases it to run, detects completion (PC reaches DONE_ADDR or
//   halt opcode) or a runaway program (RUN-cycle limit), and reports done to
//   the host with a four-phase req/done handshake.
//
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous active-low reset
//     req       in   host start request (level, four-phase)
//     prog_ctr  in   current PC from the core (D bits)
//     halt      in   decoded halt opcode, valid in the same cycle
//     step      in   single-step strobe (only with STEP_EN)
//     core_rst  out  synchronous reset to the core, active-high
//     run_en    out  PC advance / architectural write enable
//     busy      out  high in RESET and RUN
//     done      out  completion handshake to host
//     timeout   out  qualifies done: run ended by the cycle limit
//     cycle_cnt out  executed (run_en) cycles of the current/last run
//
//   Build option STEP_EN: adds the step input. In RUN, run_en is then high
//   only in the cycle after a rising edge of step, and both counting and end
//   checks happen only on those stepped cycles.
//
//   All outputs are flops; nothing combinational reaches an output pin.
// -----------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          D         = 12,
    parameter int          DONE_ADDR = 128,
    parameter int          RST_CYC   = 2,
    parameter int          CW        = 16,
    parameter int unsigned MAX_CYC   = 32'h0000_FFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    input  logic          halt,
`ifdef STEP_EN
    input  logic          step,
`endif
    output logic          core_rst,
    output logic          run_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    localparam logic [D-1:0]         DONE_PC  = D'(DONE_ADDR);
    // The limit is checked against the count before this cycle's increment,
    // so a timeout run ends with cycle_cnt exactly equal to MAX_CYC.
    localparam logic [CW-1:0]        LIMIT_M1 = CW'(MAX_CYC - 1);
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYC - 1);

    run_state_t             state_q, state_d;
    logic [RST_CNT_W-1:0]   hold_q, hold_d;
    logic                   timeout_q, timeout_d;
    logic                   core_rst_q, run_en_q, busy_q, done_q;
    logic                   cnt_clr, cnt_inc;
    logic                   end_hit, limit_hit;
    logic                   step_fire;
    logic [CW-1:0]          cnt;

`ifdef STEP_EN
    logic                   step_q;
    assign step_fire = step & ~step_q;
`else
    assign step_fire = 1'b1;
`endif

    assign end_hit   = (prog_ctr == DONE_PC) || halt;
    assign limit_hit = (cnt == LIMIT_M1);

    // Next-state and datapath control. run_en_q already marks an executing
    // cycle in both build variants, so counting and end checks key off it.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d   = RESET;
                    hold_d    = '0;
                    timeout_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            RESET: begin
                if (hold_q == RST_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (run_en_q) begin
                    cnt_inc = 1'b1;
                    // Completion outranks the limit when both land together.
                    if (end_hit) begin
                        state_d   = DONE;
                        timeout_d = 1'b0;
                    end else if (limit_hit) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            timeout_q  <= 1'b0;
            core_rst_q <= 1'b1;
            run_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef STEP_EN
            step_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            timeout_q  <= timeout_d;
            core_rst_q <= (state_d == IDLE) || (state_d == RESET);
            run_en_q   <= (state_d == RUN) && step_fire;
            busy_q     <= is_busy(state_d);
            done_q     <= (state_d == DONE);
`ifdef STEP_EN
            step_q     <= step;
`endif
        end
    end

    sat_counter #(
        .W (CW)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt)
    );

    assign core_rst  = core_rst_q;
    assign run_en    = run_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
//   Self-checking bench for run_ctrl. A behavioural model tracks the run
//   lifecycle with plain counters and flags; a negedge process compares every
//   DUT output against it each cycle. Directed scenarios add literal checks
//   (latencies and final counts), then a randomized phase exercises req, halt,
//   PC, async reset and (with STEP_EN) step.
//   MAX_CYC is set to 150 so the 129-cycle PC run completes before the limit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_run_ctrl;

    localparam int D         = 12;
    localparam int DONE_ADDR = 128;
    localparam int RST_CYC   = 2;
    localparam int CW        = 16;
    localparam int MAX_CYC   = 150;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          req      = 1'b0;
    logic [D-1:0]  prog_ctr = '0;
    logic          halt     = 1'b0;
    logic          step     = 1'b0;
    logic          core_rst, run_en, busy, done, timeout;
    logic [CW-1:0] cycle_cnt;

    always #5 clk = ~clk;

    run_ctrl #(
        .D         (D),
        .DONE_ADDR (DONE_ADDR),
        .RST_CYC   (RST_CYC),
        .CW        (CW),
        .MAX_CYC   (MAX_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .prog_ctr  (prog_ctr),
        .halt      (halt),
`ifdef STEP_EN
        .step      (step),
`endif
        .core_rst  (core_rst),
        .run_en    (run_en),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt)
    );

    int errs   = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    // hold_left > 0 : core held in reset for that many more cycles
    // running       : program executing; exec marks a cycle with run_en
    // finished      : done reported, waiting for req to drop
    int m_hold     = 0;
    bit m_running  = 1'b0;
    bit m_finished = 1'b0;
    bit m_exec     = 1'b0;
    bit m_to       = 1'b0;
    int m_cnt      = 0;
    bit m_prev_step = 1'b0;
    bit m_rise;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hold = 0; m_running = 0; m_finished = 0; m_exec = 0;
            m_to = 0; m_cnt = 0; m_prev_step = 0;
        end else begin
`ifdef STEP_EN
            m_rise = step && !m_prev_step;
`else
            m_rise = 1'b1;
`endif
            if (m_finished) begin
                if (!req) m_finished = 0;
            end else if (m_running) begin
                if (m_exec) begin
                    if (m_cnt < (2**CW) - 1) m_cnt = m_cnt + 1;
                    if (prog_ctr == DONE_ADDR || halt) begin
                        m_running = 0; m_finished = 1; m_to = 0;
                    end else if (m_cnt == MAX_CYC) begin
                        m_running = 0; m_finished = 1; m_to = 1;
                    end
                end
            end else if (m_hold > 0) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) m_running = 1;
            end else if (req) begin
                m_hold = RST_CYC; m_cnt = 0; m_to = 0;
            end
            m_exec      = m_running && m_rise;
            m_prev_step = step;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    logic [4:0] e_vec;
    always @(negedge clk) begin
        if (chk_en) begin
            e_vec = {(!m_running && !m_finished), m_exec,
                     (m_hold > 0) || m_running, m_finished, m_to};
            checks++;
            if ({core_rst, run_en, busy, done, timeout} !== e_vec ||
                cycle_cnt !== m_cnt[CW-1:0]) begin
                errs++;
                $display("FAIL model_cmp t=%0t got rst/en/busy/done/to=%b cnt=%0d expected %b cnt=%0d",
                         $time, {core_rst, run_en, busy, done, timeout}, cycle_cnt, e_vec, m_cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int pc_mode  = 0;   // 0: PC follows executed count, 1: stuck at 5
    int halt_at  = 0;   // >0: halt during executed cycle number halt_at
    bit rand_mode = 1'b0;
    bit step_auto = 1'b1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic drive_inputs();
        if (rand_mode) begin
            if ($urandom_range(0, 24) == 0) req = ~req;
            halt = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 299) == 0)
                prog_ctr = D'(DONE_ADDR);
            else if ($urandom_range(0, 1) == 0)
                prog_ctr = D'(5);
            else
                prog_ctr = D'(m_cnt);
            step = ($urandom_range(0, 1) == 1);
        end else begin
            prog_ctr = (pc_mode == 0) ? D'(m_cnt) : D'(5);
            halt = (halt_at > 0) && m_running && (m_cnt == halt_at - 1);
            if (step_auto) step = ~step;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        drive_inputs();
    endtask

    // Waits for done, counting run_en cycles seen from the call onwards.
    task automatic wait_done(input int bound, output int n_run);
        int i;
        i = 0;
        n_run = 0;
        while (!done && i < bound) begin
            if (run_en) n_run++;
            tick();
            i++;
        end
        if (!done) begin
            checks++;
            errs++;
            $display("FAIL wait_done got=done 0 after %0d cycles expected=done 1", bound);
        end
    endtask

    // Counts cycles from req until the first run_en, and core_rst cycles seen.
    task automatic measure_latency(output int lat, output int crs);
        lat = 0;
        crs = 0;
        while (!run_en && lat < 20) begin
            if (core_rst) crs++;
            tick();
            lat++;
        end
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog got=no finish expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int nr, lat, crs, held, i;

        reset = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_core_rst", core_rst, 1);
        check("rst_run_en", run_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", cycle_cnt, 0);
        reset = 1'b1;
        tick();

        // PC run to DONE_ADDR
        pc_mode = 0; halt_at = 0; req = 1'b1;
        measure_latency(lat, crs);
`ifndef STEP_EN
        check("start_latency", lat, 1 + RST_CYC);
        check("start_core_rst_cycles", crs, 1 + RST_CYC);
`endif
        wait_done(1000, nr);
        check("pc_run_cnt", cycle_cnt, 129);
        check("pc_run_timeout", timeout, 0);
        check("pc_run_en_cycles", nr, 129);

        // req held: done stays, no restart
        held = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (done && !busy) held++;
        end
        check("done_held_50", held, 50);
        check("done_held_cnt", cycle_cnt, 129);
        req = 1'b0;
        tick();
        check("done_falls", done, 0);

        // halt at executed cycle 10, req dropped mid-run
        pc_mode = 1; halt_at = 10; req = 1'b1;
        repeat (6) tick();
        req = 1'b0;
        wait_done(1000, nr);
        check("halt_cnt", cycle_cnt, 10);
        check("halt_timeout", timeout, 0);
        tick();

        // timeout with PC stuck
        pc_mode = 1; halt_at = 0; req = 1'b1;
        wait_done(1000, nr);
        check("timeout_flag", timeout, 1);
        check("timeout_cnt", cycle_cnt, MAX_CYC);
        req = 1'b0;
        tick();

        // halt on the limit cycle: completion wins
        halt_at = MAX_CYC; req = 1'b1;
        wait_done(1000, nr);
        check("limit_halt_timeout", timeout, 0);
        check("limit_halt_cnt", cycle_cnt, MAX_CYC);
        req = 1'b0;
        tick();

        // async reset mid-run
        halt_at = 0; req = 1'b1;
        nr = 0; i = 0;
        while (nr < 5 && i < 100) begin
            if (run_en) nr++;
            tick();
            i++;
        end
        check("midrun_reached", nr, 5);
        reset = 1'b0;
        #1;
        check("midrun_core_rst", core_rst, 1);
        check("midrun_run_en", run_en, 0);
        check("midrun_busy", busy, 0);
        check("midrun_done", done, 0);
        check("midrun_cnt", cycle_cnt, 0);
        tick();
        reset = 1'b1;
        measure_latency(lat, crs);
`ifndef STEP_EN
        check("restart_latency", lat, 1 + RST_CYC);
`endif
        check("restart_busy", busy, 1);
        wait_done(1000, nr);
        req = 1'b0;
        tick();

`ifdef STEP_EN
        // exactly three step pulses -> three executed cycles
        step_auto = 1'b0; step = 1'b0; req = 1'b1;
        repeat (RST_CYC + 4) tick();
        nr = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick();
            if (run_en) nr++;
            step = 1'b0;
            tick();
            if (run_en) nr++;
            tick();
            if (run_en) nr++;
        end
        check("step_run_en_cycles", nr, 3);
        check("step_cnt", cycle_cnt, 3);
        reset = 1'b0;
        tick();
        reset = 1'b1; req = 1'b0;
        tick();
`endif

        // randomized phase
        rand_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
